// File: rtl/debounce_bank.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_bank
//  Description : Multi-channel input conditioner for buttons and switches.
//                Each channel has an NSYNC-flop synchroniser, a
//                stability-count debouncer, and registered rise/fall pulses.
//                press_out reports every rise. When AUTO_REPEAT_EN is
//                defined, it also reports auto-repeat pulses while the
//                input is held.
//  Macro       : AUTO_REPEAT_EN (undefined by default: press_out == rise_out)
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_bank #(
    parameter int               NCHAN           = 8,
    parameter int               NSYNC           = 3,
    parameter int               DEBOUNCE_CYCLES = 1_000_000,
    parameter logic [NCHAN-1:0] RESET_VAL       = '0,
    parameter int               REPEAT_DELAY    = 50_000_000,
    parameter int               REPEAT_PERIOD   = 10_000_000
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [NCHAN-1:0] noisy_in,
    output logic [NCHAN-1:0] clean_out,
    output logic [NCHAN-1:0] rise_out,
    output logic [NCHAN-1:0] fall_out,
    output logic [NCHAN-1:0] press_out
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef AUTO_REPEAT_EN
    localparam int              RMAX        = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int              RC_W        = $clog2(RMAX + 1);
    localparam logic [RC_W-1:0] DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
    localparam logic [RC_W-1:0] PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);

    typedef enum logic {
        PH_FIRST  = 1'b0,
        PH_REPEAT = 1'b1
    } phase_t;
`endif

    // Reject parameter sets the logic below cannot honour.
    if (NSYNC < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("debounce_bank: illegal parameter value");
    end

    logic [NCHAN-1:0] sync_q [NSYNC];
    logic [NCHAN-1:0] synced;

    // Synchroniser chain: all channels shift together; the last stage feeds the debouncers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int k = 0; k < NSYNC; k++) begin
                sync_q[k] <= RESET_VAL;
            end
        end else begin
            sync_q[0] <= noisy_in;
            for (int k = 1; k < NSYNC; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign synced = sync_q[NSYNC-1];

    for (genvar i = 0; i < NCHAN; i++) begin : g_chan
        logic [CNT_W-1:0] cnt;
        logic             clean;
        logic             rise;
        logic             fall;
        logic             flip;
        logic             rise_next;
        logic             fall_next;

        // The level is accepted on the last consecutive mismatch cycle.
        assign flip      = (synced[i] != clean) && (cnt == CNT_LAST);
        assign rise_next = flip &  synced[i];
        assign fall_next = flip & ~synced[i];

        // Debounce counter: any cycle that matches the accepted level restarts the count.
        always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
                cnt   <= '0;
                clean <= RESET_VAL[i];
                rise  <= 1'b0;
                fall  <= 1'b0;
            end else begin
                rise <= rise_next;
                fall <= fall_next;
                if ((synced[i] == clean) || flip) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                if (flip) begin
                    clean <= synced[i];
                end
            end
        end

        assign clean_out[i] = clean;
        assign rise_out[i]  = rise;
        assign fall_out[i]  = fall;

`ifdef AUTO_REPEAT_EN
        logic [RC_W-1:0] rcnt;
        phase_t          phase;
        logic            rep;

        // Auto-repeat FSM. The first pulse comes REPEAT_DELAY cycles after the rise.
        // Later pulses come every REPEAT_PERIOD cycles. A fall or a low level re-arms it.
        always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
                rcnt  <= '0;
                phase <= PH_FIRST;
                rep   <= 1'b0;
            end else begin
                rep <= 1'b0;
                if (rise_next || fall_next || !clean) begin
                    rcnt  <= '0;
                    phase <= PH_FIRST;
                end else if (phase == PH_FIRST && rcnt == DELAY_LAST) begin
                    rep   <= 1'b1;
                    rcnt  <= '0;
                    phase <= PH_REPEAT;
                end else if (phase == PH_REPEAT && rcnt == PERIOD_LAST) begin
                    rep  <= 1'b1;
                    rcnt <= '0;
                end else begin
                    rcnt <= rcnt + RC_W'(1);
                end
            end
        end

        assign press_out[i] = rise | rep;
`else
        assign press_out[i] = rise;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_debounce_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debounce_bank
//  Description : Self-checking bench for debounce_bank (4 channels, NSYNC=2,
//                DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5).
//                The reference model works from a per-edge input history and
//                mismatch run lengths; repeat pulses are derived arithmetically
//                from the rise edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_bank;

    localparam int         NCH  = 4;
    localparam int         NSY  = 2;
    localparam int         DEB  = 8;
    localparam int         RD   = 20;
    localparam int         RP   = 5;
    localparam logic [3:0] RSTV = 4'b0000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] noisy;
    logic [3:0] clean_out, rise_out, fall_out, press_out;

    debounce_bank #(
        .NCHAN           (NCH),
        .NSYNC           (NSY),
        .DEBOUNCE_CYCLES (DEB),
        .RESET_VAL       (RSTV),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk_in    (clk),
        .rst_n_in  (rst_n),
        .noisy_in  (noisy),
        .clean_out (clean_out),
        .rise_out  (rise_out),
        .fall_out  (fall_out),
        .press_out (press_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int         e;
    logic [3:0] hist[$];
    logic [3:0] m_clean, m_rise, m_fall, m_press;
    int         run[4];
    int         rise_at[4];

    // observation trackers (from DUT outputs)
    int   obs_rise[4];
    int   obs_fall[4];
    int   press_cnt[4];
    logic act2;

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s edge %0d: observed %b expected %b", tag, e, obs, exp);
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        e = 0;
        hist.delete();
        m_clean = RSTV;
        m_rise  = '0;
        m_fall  = '0;
        m_press = '0;
        for (int c = 0; c < NCH; c++) begin
            run[c]     = 0;
            rise_at[c] = 0;
        end
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_edge();
        logic sv;
        int   d;
        e++;
        hist.push_back(noisy);
        m_rise  = '0;
        m_fall  = '0;
        m_press = '0;
        for (int c = 0; c < NCH; c++) begin
            // the debouncer sees the pin value from NSY edges ago
            if (e > NSY) sv = hist[e-1-NSY][c];
            else         sv = RSTV[c];
            if (sv !== m_clean[c]) begin
                run[c]++;
                if (run[c] == DEB) begin
                    m_clean[c] = sv;
                    run[c]     = 0;
                    if (sv) begin
                        m_rise[c]  = 1'b1;
                        rise_at[c] = e;
                    end else begin
                        m_fall[c] = 1'b1;
                    end
                end
            end else begin
                run[c] = 0;
            end
            m_press[c] = m_rise[c];
`ifdef AUTO_REPEAT_EN
            if (m_clean[c] && !m_rise[c]) begin
                d = e - rise_at[c];
                if (d == RD || (d > RD && ((d - RD) % RP) == 0)) m_press[c] = 1'b1;
            end
`endif
        end
    endtask

    // Drive one input vector, let one edge happen, compare, return at the next negedge.
    task automatic step(input logic [3:0] v);
        noisy = v;
        @(posedge clk);
        model_edge();
        #1;
        chk4("clean_out", clean_out, m_clean);
        chk4("rise_out",  rise_out,  m_rise);
        chk4("fall_out",  fall_out,  m_fall);
        chk4("press_out", press_out, m_press);
        for (int c = 0; c < NCH; c++) begin
            if (rise_out[c])  obs_rise[c] = e;
            if (fall_out[c])  obs_fall[c] = e;
            if (press_out[c]) press_cnt[c]++;
        end
        act2 = act2 | clean_out[2] | rise_out[2] | fall_out[2];
        @(negedge clk);
    endtask

    initial begin
        int         t;
        int         hold[4];
        logic [3:0] lvl;
        logic       b;

        rst_n = 1'b0;
        noisy = 4'b0000;
        act2  = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            obs_rise[c]  = -1;
            obs_fall[c]  = -1;
            press_cnt[c] = 0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        chk4("reset_clean", clean_out, 4'b0000);
        chk4("reset_rise",  rise_out,  4'b0000);
        chk4("reset_fall",  fall_out,  4'b0000);
        chk4("reset_press", press_out, 4'b0000);
        rst_n = 1'b1;

        // 1: clean rise on ch0, ten edges after the pin changes
        t = e;
        repeat (14) step(4'b0001);
        chk_int("t1_rise_edge_ch0", obs_rise[0], t + 10);

        // 4: release ch0, fall ten edges later, no rise
        t = e;
        obs_rise[0] = -1;
        repeat (14) step(4'b0000);
        chk_int("t4_fall_edge_ch0", obs_fall[0], t + 10);
        chk_int("t4_no_rise_ch0", obs_rise[0], -1);

        // 2: ch1 bounces every 3 cycles, then settles high
        for (int k = 0; k < 30; k++) begin
            b = ((k / 3) % 2) == 0;
            step({2'b00, b, 1'b0});
        end
        chk_int("t2_no_rise_bounce", obs_rise[1], -1);
        chk_int("t2_no_fall_bounce", obs_fall[1], -1);
        t = e;
        repeat (15) step(4'b0010);
        chk_int("t2_rise_edge_ch1", obs_rise[1], t + 10);

        // 3: ch2 high for 7 cycles only, never accepted
        act2 = 1'b0;
        repeat (7)  step(4'b0110);
        repeat (20) step(4'b0010);
        chk_int("t3_ch2_silent", int'(act2), 0);

        // 5: hold ch0, count press pulses until well after the fall
        press_cnt[0] = 0;
        repeat (57) step(4'b0001);
        repeat (30) step(4'b0000);
`ifdef AUTO_REPEAT_EN
        chk_int("t5_press_count_ch0", press_cnt[0], 9);
`else
        chk_int("t5_press_count_ch0", press_cnt[0], 1);
`endif

        // 6: async reset with ch0 in repeat phase and ch3 mid-count
        repeat (35) step(4'b0001);
        repeat (7)  step(4'b1001);
        rst_n = 1'b0;
        #1;
        chk4("t6_async_clean", clean_out, 4'b0000);
        chk4("t6_async_rise",  rise_out,  4'b0000);
        chk4("t6_async_press", press_out, 4'b0000);
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            chk4("t6_hold_clean", clean_out, 4'b0000);
            chk4("t6_hold_press", press_out, 4'b0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        obs_rise[0] = -1;
        obs_rise[3] = -1;
        repeat (15) step(4'b1001);
        chk_int("t6_rise_edge_ch0", obs_rise[0], NSY + DEB);
        chk_int("t6_rise_edge_ch3", obs_rise[3], NSY + DEB);

        // randomized levels with random hold lengths on all channels
        lvl = 4'b1001;
        for (int c = 0; c < NCH; c++) hold[c] = 0;
        for (int k = 0; k < 600; k++) begin
            for (int c = 0; c < NCH; c++) begin
                if (hold[c] == 0) begin
                    lvl[c]  = 1'($urandom_range(0, 1));
                    hold[c] = int'($urandom_range(1, 14));
                end
                hold[c]--;
            end
            step(lvl);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
